// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: opcodes, CPU states, operate-group
// bit positions, autoindex window, panel bit map, 7-seg decode.
package pdp8_pkg;

   localparam int AW = 12;
   localparam int DW = 12;

   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_TAD = 3'd1,
      OP_ISZ = 3'd2,
      OP_DCA = 3'd3,
      OP_JMS = 3'd4,
      OP_JMP = 3'd5,
      OP_IOT = 3'd6,
      OP_OPR = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DEFER = 3'd2,
      S_EXEC  = 3'd3,
      S_WB    = 3'd4
   } state_e;

   localparam int G1_CLA = 7;
   localparam int G1_CLL = 6;
   localparam int G1_CMA = 5;
   localparam int G1_CML = 4;
   localparam int G1_RAR = 3;
   localparam int G1_RAL = 2;
   localparam int G1_TWO = 1;
   localparam int G1_IAC = 0;

   localparam int G2_CLA = 7;
   localparam int G2_SMA = 6;
   localparam int G2_SZA = 5;
   localparam int G2_SNL = 4;
   localparam int G2_REV = 3;
   localparam int G2_OSR = 2;
   localparam int G2_HLT = 1;

   localparam logic [AW-1:0] AUTO_LO = 12'o0010;
   localparam logic [AW-1:0] AUTO_HI = 12'o0017;

   // panel input bit positions in the synchronizer vector
   localparam int B_LDAC = 0;
   localparam int B_LDPC = 1;
   localparam int B_DEP  = 2;
   localparam int B_STEP = 3;
   localparam int B_DISP = 4;
   localparam int B_RUN  = 5;

   function automatic logic is_auto(input logic [AW-1:0] a);
      return (a >= AUTO_LO) && (a <= AUTO_HI);
   endfunction

   // octal digit to active-low segments, seg[0]=CA .. seg[6]=CG
   function automatic logic [6:0] seg_lo(input logic [2:0] d);
      logic [6:0] p;
      unique case (d)
         3'd0: p = 7'h3F;
         3'd1: p = 7'h06;
         3'd2: p = 7'h5B;
         3'd3: p = 7'h4F;
         3'd4: p = 7'h66;
         3'd5: p = 7'h6D;
         3'd6: p = 7'h7D;
         default: p = 7'h07;
      endcase
      return ~p;
   endfunction

endpackage

// File: rtl/pdp8_mem.sv
// 4096x12 main memory, single port, synchronous read (1 cycle).
// Ports: clk, we, addr, wdata -> rdata (old data on write cycle).
module pdp8_mem
   import pdp8_pkg::*;
(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] memory [4096];

   always_ff @(posedge clk) begin
      if (we) memory[addr] <= wdata;
      rdata <= memory[addr];
   end

endmodule

// File: rtl/pdp8_top.sv
// PDP-8 board top: CPU core, panel buttons/switches, octal display.
// Ports: clk, btnCpuReset, btn[c,u,d,l,r], sw -> led, an, seg, dp.
module pdp8_top
   import pdp8_pkg::*;
#(
   parameter int REFRESH_BITS = 17
) (
   input  logic        clk,
   input  logic        btnCpuReset,
   input  logic        btnc,
   input  logic        btnu,
   input  logic        btnd,
   input  logic        btnl,
   input  logic        btnr,
   input  logic [12:0] sw,
   output logic [15:0] led,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   logic [11:0] pc, ac, ir, mb, ea;
   logic        lnk, running, show_mb;
   state_e      state;
   logic [1:0]  ph;

   logic [5:0]  raw, s1, s2, s3, rise;
   logic        sw_run, cont, panel_ok;
   logic        act_ldpc, act_ldac, act_dep, act_step;

   logic        mem_we;
   logic [11:0] mem_addr, mem_wd, mem_rd;

   logic [11:0] opr_ac;
   logic        opr_l, opr_skip, opr_halt, cond;
   opcode_e     op;

   logic [REFRESH_BITS-1:0] scan_cnt;
   logic [2:0]  digit;
   logic [23:0] shown;
   logic [2:0]  nib;

   assign raw    = {sw[12], btnc, btnu, btnd, btnl, btnr};
   assign rise   = s2 & ~s3;
   assign sw_run = s2[B_RUN];
   assign cont   = running & sw_run;
   assign op     = opcode_e'(ir[11:9]);

   // panel acts only at rest; one action per cycle, by priority
   assign panel_ok = (state == S_IDLE) && !running && !rise[B_RUN];
   assign act_ldpc = panel_ok & rise[B_LDPC];
   assign act_ldac = panel_ok & rise[B_LDAC] & ~rise[B_LDPC];
   assign act_dep  = panel_ok & rise[B_DEP]
                   & ~rise[B_LDPC] & ~rise[B_LDAC];
   assign act_step = panel_ok & rise[B_STEP]
                   & ~rise[B_LDPC] & ~rise[B_LDAC] & ~rise[B_DEP];

   pdp8_mem MEM0 (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wd),
      .rdata (mem_rd)
   );

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = pc;
      mem_wd   = sw[11:0];
      unique case (state)
         S_IDLE:  mem_we = act_dep;
         S_DEFER: begin
            mem_addr = ea;
            mem_we   = (ph == 2'd2);
            mem_wd   = mb + 12'd1;
         end
         S_EXEC:  mem_addr = ea;
         S_WB: begin
            mem_addr = ea;
            mem_we   = 1'b1;
            if (op == OP_ISZ)      mem_wd = mb;
            else if (op == OP_DCA) mem_wd = ac;
            else                   mem_wd = pc;
         end
         default: ;
      endcase
   end

   // operate microinstructions, evaluated in strict group order
   always_comb begin
      opr_ac   = ac;
      opr_l    = lnk;
      opr_skip = 1'b0;
      opr_halt = 1'b0;
      cond     = 1'b0;
      unique case (1'b1)
         (op == OP_OPR) && !ir[8]: begin
            if (ir[G1_CLA]) opr_ac = '0;
            if (ir[G1_CLL]) opr_l  = 1'b0;
            if (ir[G1_CMA]) opr_ac = ~opr_ac;
            if (ir[G1_CML]) opr_l  = ~opr_l;
            if (ir[G1_IAC]) {opr_l, opr_ac} = {opr_l, opr_ac} + 13'd1;
            if (ir[G1_RAR]) begin
               {opr_l, opr_ac} = {opr_ac[0], opr_l, opr_ac[11:1]};
               if (ir[G1_TWO])
                  {opr_l, opr_ac} = {opr_ac[0], opr_l, opr_ac[11:1]};
            end
            if (ir[G1_RAL]) begin
               {opr_l, opr_ac} = {opr_ac, opr_l};
               if (ir[G1_TWO])
                  {opr_l, opr_ac} = {opr_ac, opr_l};
            end
         end
         (op == OP_OPR) && ir[8] && !ir[0]: begin
            cond = (ir[G2_SMA] & ac[11])
                 | (ir[G2_SZA] & (ac == 12'd0))
                 | (ir[G2_SNL] & lnk);
            // reverse sense: AND of the negated selected conditions
            opr_skip = cond ^ ir[G2_REV];
            if (ir[G2_CLA]) opr_ac = '0;
            if (ir[G2_OSR]) opr_ac = opr_ac | sw[11:0];
            opr_halt = ir[G2_HLT];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (btnCpuReset) begin
         pc      <= '0;
         ac      <= '0;
         lnk     <= 1'b0;
         ir      <= '0;
         mb      <= '0;
         ea      <= '0;
         running <= 1'b0;
         show_mb <= 1'b0;
         state   <= S_IDLE;
         ph      <= '0;
         s1      <= '0;
         s2      <= '0;
         s3      <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
         if (rise[B_RUN]) running <= 1'b1;
         if (!running && rise[B_DISP]) show_mb <= ~show_mb;
         unique case (state)
            S_IDLE: begin
               ph <= '0;
               if (running)       state <= S_FETCH;
               else if (act_ldpc) pc    <= sw[11:0];
               else if (act_ldac) ac    <= sw[11:0];
               else if (act_dep)  pc    <= pc + 12'd1;
               else if (act_step) state <= S_FETCH;
            end
            S_FETCH: begin
               if (ph == 2'd0) ph <= 2'd1;
               else begin
                  ph <= '0;
                  ir <= mem_rd;
                  mb <= mem_rd;
                  pc <= pc + 12'd1;
                  // page bits come from the fetch address
                  ea <= {mem_rd[7] ? pc[11:7] : 5'b0, mem_rd[6:0]};
                  if (mem_rd[11:10] == 2'b11 || !mem_rd[8])
                     state <= S_EXEC;
                  else
                     state <= S_DEFER;
               end
            end
            S_DEFER: begin
               unique case (ph)
                  2'd0: ph <= 2'd1;
                  2'd1: begin
                     mb <= mem_rd;
                     if (is_auto(ea)) ph <= 2'd2;
                     else begin
                        ea    <= mem_rd;
                        ph    <= '0;
                        state <= S_EXEC;
                     end
                  end
                  default: begin
                     ea    <= mb + 12'd1;
                     ph    <= '0;
                     state <= S_EXEC;
                  end
               endcase
            end
            S_EXEC: begin
               if (op == OP_IOT || op == OP_OPR) begin
                  ac  <= opr_ac;
                  lnk <= opr_l;
                  if (opr_skip) pc <= pc + 12'd1;
                  if (opr_halt) begin
                     running <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     running <= cont | rise[B_RUN];
                     state   <= cont ? S_FETCH : S_IDLE;
                  end
               end else if (ph == 2'd0) begin
                  ph <= 2'd1;
               end else begin
                  ph <= '0;
                  unique case (op)
                     OP_AND: begin
                        ac      <= ac & mem_rd;
                        mb      <= mem_rd;
                        running <= cont | rise[B_RUN];
                        state   <= cont ? S_FETCH : S_IDLE;
                     end
                     OP_TAD: begin
                        {lnk, ac} <= {lnk, ac} + {1'b0, mem_rd};
                        mb        <= mem_rd;
                        running   <= cont | rise[B_RUN];
                        state     <= cont ? S_FETCH : S_IDLE;
                     end
                     OP_ISZ: begin
                        mb    <= mem_rd + 12'd1;
                        state <= S_WB;
                     end
                     OP_JMP: begin
                        pc      <= ea;
                        running <= cont | rise[B_RUN];
                        state   <= cont ? S_FETCH : S_IDLE;
                     end
                     default: state <= S_WB;
                  endcase
               end
            end
            S_WB: begin
               if (op == OP_ISZ && mb == 12'd0) pc <= pc + 12'd1;
               if (op == OP_DCA) ac <= '0;
               if (op == OP_JMS) pc <= ea + 12'd1;
               running <= cont | rise[B_RUN];
               state   <= cont ? S_FETCH : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (btnCpuReset) begin
         scan_cnt <= '0;
         digit    <= '0;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         if (&scan_cnt) digit <= digit + 3'd1;
      end
   end

   assign shown = {pc, show_mb ? mb : ac};
   assign nib   = shown[5'(digit) * 5'd3 +: 3];
   assign an    = ~(8'd1 << digit);
   assign seg   = seg_lo(nib);
   assign dp    = 1'b1;
   assign led   = {2'b00, lnk, running, ac};

endmodule

// File: tb/tb_pdp8_top.sv
// Directed bench for pdp8_top: panel, deposit wrap, programs,
// autoindex, ISZ skip, single-step IAC and the octal display.
module tb_pdp8_top;

   logic        clk = 1'b0;
   logic        btnCpuReset, btnc, btnu, btnd, btnl, btnr;
   logic [12:0] sw;
   logic [15:0] led;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_assert = 0;
   int n_fail   = 0;
   int run_cnt  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (led[12]) run_cnt++;

   pdp8_top #(.REFRESH_BITS(2)) dut (
      .clk         (clk),
      .btnCpuReset (btnCpuReset),
      .btnc        (btnc),
      .btnu        (btnu),
      .btnd        (btnd),
      .btnl        (btnl),
      .btnr        (btnr),
      .sw          (sw),
      .led         (led),
      .an          (an),
      .seg         (seg),
      .dp          (dp)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // 0=load PC, 1=load AC, 2=deposit, 3=step, 4=display select
   task automatic press(input int b);
      case (b)
         0: btnl = 1'b1;
         1: btnr = 1'b1;
         2: btnd = 1'b1;
         3: btnu = 1'b1;
         default: btnc = 1'b1;
      endcase
      tick(1);
      {btnc, btnu, btnd, btnl, btnr} = '0;
      tick(5);
   endtask

   task automatic load_pc(input logic [11:0] v);
      sw[11:0] = v;
      press(0);
   endtask

   task automatic load_ac(input logic [11:0] v);
      sw[11:0] = v;
      press(1);
   endtask

   task automatic deposit(input logic [11:0] v);
      sw[11:0] = v;
      press(2);
   endtask

   task automatic wait_an(input string tag, input logic [7:0] want);
      int k = 0;
      while (an !== want && k < 64) begin
         tick(1);
         k++;
      end
      check(tag, an, want);
   endtask

   task automatic run_prog(input string tag);
      int   k = 0;
      logic rose = 1'b0;
      sw[12] = 1'b1;
      while (k < 3000) begin
         tick(1);
         k++;
         if (led[12]) rose = 1'b1;
         else if (rose) break;
      end
      check({tag, " started"}, rose, 1);
      check({tag, " halted"}, led[12], 0);
      sw[12] = 1'b0;
      tick(4);
   endtask

   function automatic logic [11:0] img(input int i);
      return 12'((i * 37 + 11) & 4095);
   endfunction

   initial begin
      int mism;
      int base;
      btnCpuReset = 1'b1;
      {btnc, btnu, btnd, btnl, btnr} = '0;
      sw = '0;

      tick(5);
      btnCpuReset = 1'b0;
      check("reset led", led, 16'h0000);
      check("reset an", an, 8'hFE);
      check("reset dp", dp, 1);
      check("reset seg", seg, 7'h40);
      check("reset pc", dut.pc, 0);

      // load AC lands exactly on the third edge
      sw[11:0] = 12'o0123;
      btnr = 1'b1;
      tick(1);
      btnr = 1'b0;
      tick(1);
      check("ldac early", led[11:0], 0);
      tick(1);
      check("ldac edge3", led[11:0], 12'o0123);
      tick(4);

      load_ac(12'o0005);
      wait_an("scan d0", 8'hFE);
      check("seg ac=5", seg, 7'h12);
      press(4);
      wait_an("scan d0 mb", 8'hFE);
      check("seg mb=0", seg, 7'h40);
      press(4);
      load_pc(12'o0200);
      check("ldpc", dut.pc, 12'o0200);
      wait_an("scan d6", 8'hBF);
      check("seg pc d6", seg, 7'h24);

      load_pc(12'o0000);
      for (int i = 0; i < 4096; i++) deposit(img(i));
      check("dep wrap pc", dut.pc, 0);
      mism = 0;
      for (int i = 0; i < 4096; i++)
         if (dut.MEM0.memory[i] !== img(i)) mism++;
      check("image words bad", mism, 0);
      check("mem 7777", dut.MEM0.memory[4095], img(4095));

      load_pc(12'o0200);
      deposit(12'o7200);
      deposit(12'o1205);
      deposit(12'o3206);
      deposit(12'o7402);
      load_pc(12'o0205);
      deposit(12'o0017);
      load_pc(12'o0200);
      run_prog("prog1");
      check("prog1 m0206", dut.MEM0.memory[12'o0206], 12'o0017);
      check("prog1 ac", led[11:0], 0);

      load_pc(12'o0010);
      deposit(12'o0377);
      load_pc(12'o0400);
      deposit(12'o0005);
      load_pc(12'o0200);
      deposit(12'o1410);
      deposit(12'o7402);
      load_ac(12'o0000);
      load_pc(12'o0200);
      run_prog("autoidx");
      check("autoidx ptr", dut.MEM0.memory[12'o0010], 12'o0400);
      check("autoidx ac", led[11:0], 12'o0005);

      load_pc(12'o0300);
      deposit(12'o7777);
      load_pc(12'o0200);
      deposit(12'o2300);
      load_pc(12'o0200);
      press(3);
      tick(10);
      check("isz mem", dut.MEM0.memory[12'o0300], 0);
      check("isz pc", dut.pc, 12'o0202);
      check("isz idle", led[12], 0);

      btnCpuReset = 1'b1;
      tick(3);
      btnCpuReset = 1'b0;
      check("reset2 led", led, 16'h0000);
      load_ac(12'o7777);
      check("iac pre ac", led[11:0], 12'o7777);
      load_pc(12'o0200);
      deposit(12'o7001);
      load_pc(12'o0200);
      base = run_cnt;
      press(3);
      tick(10);
      check("iac ac", led[11:0], 0);
      check("iac link", led[13], 1);
      check("iac pc", dut.pc, 12'o0201);
      check("iac no run", run_cnt - base, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
